// File: rtl/mul_seq_pkg.sv
// Shared types for the multiply sequencer: FSM states, captured op descriptor,
// write-port select codes and the N/Z flag helper.
package mul_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL  = 3'd1,
      S_ACC  = 3'd2,
      S_WLO  = 3'd3,
      S_WHI  = 3'd4
   } state_t;

   typedef struct packed {
      logic long_en;
      logic signed_en;
      logic acc_en;
      logic set_flags;
   } mul_op_t;

   localparam logic WR_SEL_LO = 1'b0;
   localparam logic WR_SEL_HI = 1'b1;

   // Returns {N, Z}; short ops only look at the low word.
   function automatic logic [1:0] calc_flags(input logic [63:0] res, input logic is_long);
      logic [1:0] f;
      if (is_long) f = {res[63], (res == 64'd0)};
      else         f = {res[31], (res[31:0] == 32'd0)};
      return f;
   endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response bundle between the main control FSM (master) and the
// multiply sequencer (slave).
interface mul_seq_if #(parameter int XLEN = 32);

   logic            start;
   logic            long_en;
   logic            signed_en;
   logic            acc_en;
   logic            set_flags;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [XLEN-1:0] acc_lo;
   logic [XLEN-1:0] acc_hi;

   logic            busy;
   logic            done;
   logic            wr_en;
   logic            wr_sel;
   logic [XLEN-1:0] wr_data;
   logic            flags_we;
   logic            flag_n;
   logic            flag_z;

   modport master (
      output start, long_en, signed_en, acc_en, set_flags, a, b, acc_lo, acc_hi,
      input  busy, done, wr_en, wr_sel, wr_data, flags_we, flag_n, flag_z
   );

   modport slave (
      input  start, long_en, signed_en, acc_en, set_flags, a, b, acc_lo, acc_hi,
      output busy, done, wr_en, wr_sel, wr_data, flags_we, flag_n, flag_z
   );

endinterface

// File: rtl/mul_seq_umul32.sv
// Purely combinational unsigned XLEN x XLEN -> 2*XLEN multiplier.
module umul32 #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]   i_a,
   input  logic [XLEN-1:0]   i_b,
   output logic [2*XLEN-1:0] o_p
);

   logic [2*XLEN-1:0] w_a_ext;
   logic [2*XLEN-1:0] w_b_ext;

   assign w_a_ext = {{XLEN{1'b0}}, i_a};
   assign w_b_ext = {{XLEN{1'b0}}, i_b};
   assign o_p     = w_a_ext * w_b_ext;

endmodule

// File: rtl/mul_seq.sv
// Multicycle sequencer for MUL/MLA/UMULL/UMLAL/SMULL/SMLAL around umul32.
// Build option: define MUL_SIGNED_EN to enable signed long multiplies.
//
// state  | meaning
// S_IDLE | waiting for start; inputs captured on accept
// S_MUL  | product register loads (sign-corrected) multiplier output
// S_ACC  | accumulator added into product register
// S_WLO  | write result low word (Rd / RdLo)
// S_WHI  | write result high word (RdHi), long ops only
module mul_seq
   import mul_seq_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   mul_seq_if.slave   bus
);

   state_t            r_state;
   state_t            w_state_nxt;
   mul_op_t           r_op;
   logic [XLEN-1:0]   r_a;
   logic [XLEN-1:0]   r_b;
   logic [XLEN-1:0]   r_acc_lo;
   logic [XLEN-1:0]   r_acc_hi;
   logic [2*XLEN-1:0] r_res;
   logic              r_flag_n;
   logic              r_flag_z;

   logic [XLEN-1:0]   w_mag_a;
   logic [XLEN-1:0]   w_mag_b;
   logic [2*XLEN-1:0] w_uprod;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_res_nxt;
   logic              w_flag_ld;
   logic [1:0]        w_flags_nxt;

   logic              w_busy;
   logic              w_done;
   logic              w_wr_en;
   logic              w_wr_sel;
   logic [XLEN-1:0]   w_wr_data;

`ifdef MUL_SIGNED_EN
   logic w_signed;
   logic w_neg;

   // 0x80000000 negates to itself, which read unsigned is the correct 2^31.
   assign w_signed = r_op.long_en & r_op.signed_en;
   assign w_neg    = w_signed & (r_a[XLEN-1] ^ r_b[XLEN-1]);
   assign w_mag_a  = (w_signed & r_a[XLEN-1]) ? -r_a : r_a;
   assign w_mag_b  = (w_signed & r_b[XLEN-1]) ? -r_b : r_b;
   assign w_prod   = w_neg ? -w_uprod : w_uprod;
`else
   logic w_unused_signed;

   assign w_unused_signed = r_op.signed_en;
   assign w_mag_a         = r_a;
   assign w_mag_b         = r_b;
   assign w_prod          = w_uprod;
`endif

   umul32 #(.XLEN(XLEN)) u_umul32 (
      .i_a (w_mag_a),
      .i_b (w_mag_b),
      .o_p (w_uprod)
   );

   always_comb begin
      w_res_nxt = r_res;
      case (r_state)
         S_MUL: begin
            if (r_op.long_en) w_res_nxt = w_prod;
            else              w_res_nxt = {{XLEN{1'b0}}, w_prod[XLEN-1:0]};
         end
         S_ACC: begin
            if (r_op.long_en) w_res_nxt = r_res + {r_acc_hi, r_acc_lo};
            else              w_res_nxt = {{XLEN{1'b0}}, r_res[XLEN-1:0] + r_acc_lo};
         end
         default: w_res_nxt = r_res;
      endcase
   end

   // Flags load on entry to the final write cycle so they change only there.
   always_comb begin
      w_flag_ld   = 1'b0;
      w_flags_nxt = {r_flag_n, r_flag_z};
      if (!r_op.long_en &&
          (((r_state == S_MUL) && !r_op.acc_en) || (r_state == S_ACC))) begin
         w_flag_ld   = 1'b1;
         w_flags_nxt = calc_flags(w_res_nxt, 1'b0);
      end else if (r_op.long_en && (r_state == S_WLO)) begin
         w_flag_ld   = 1'b1;
         w_flags_nxt = calc_flags(r_res, 1'b1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_op     <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_acc_lo <= '0;
         r_acc_hi <= '0;
         r_res    <= '0;
         r_flag_n <= 1'b0;
         r_flag_z <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && bus.start) begin
            r_op.long_en   <= bus.long_en;
            r_op.signed_en <= bus.signed_en;
            r_op.acc_en    <= bus.acc_en;
            r_op.set_flags <= bus.set_flags;
            r_a            <= bus.a;
            r_b            <= bus.b;
            r_acc_lo       <= bus.acc_lo;
            r_acc_hi       <= bus.acc_hi;
         end
         r_res <= w_res_nxt;
         if (w_flag_ld) begin
            r_flag_n <= w_flags_nxt[1];
            r_flag_z <= w_flags_nxt[0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      w_done      = 1'b0;
      w_wr_en     = 1'b0;
      w_wr_sel    = WR_SEL_LO;
      w_wr_data   = '0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) w_state_nxt = S_MUL;
         end
         S_MUL: begin
            w_busy      = 1'b1;
            w_state_nxt = r_op.acc_en ? S_ACC : S_WLO;
         end
         S_ACC: begin
            w_busy      = 1'b1;
            w_state_nxt = S_WLO;
         end
         S_WLO: begin
            w_busy      = 1'b1;
            w_wr_en     = 1'b1;
            w_wr_sel    = WR_SEL_LO;
            w_wr_data   = r_res[XLEN-1:0];
            w_done      = ~r_op.long_en;
            w_state_nxt = r_op.long_en ? S_WHI : S_IDLE;
         end
         S_WHI: begin
            w_busy      = 1'b1;
            w_wr_en     = 1'b1;
            w_wr_sel    = WR_SEL_HI;
            w_wr_data   = r_res[2*XLEN-1:XLEN];
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.wr_en    = w_wr_en;
   assign bus.wr_sel   = w_wr_sel;
   assign bus.wr_data  = w_wr_data;
   assign bus.flags_we = w_done & r_op.set_flags;
   assign bus.flag_n   = r_flag_n;
   assign bus.flag_z   = r_flag_z;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed cases, random ops, reset abort.
module tb_mul_seq;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   int   cyc     = 0;
   int   n_vec   = 0;
   int   n_err   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_seq_if #(.XLEN(32)) bus ();

   mul_seq #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic        busy;
      logic        done;
      logic        wr_en;
      logic        wr_sel;
      logic [31:0] data;
      logic        fwe;
      logic        upd;
      logic        fn;
      logic        fz;
   } exp_t;

   exp_t exp_m [int];
   logic exp_fn = 1'b0;
   logic exp_fz = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
      n_vec++;
      if (act !== ex) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, ex, $time);
      end
   endtask

   // Reference result from plain integer arithmetic.
   function automatic logic [63:0] model_res(input bit lng, input bit sgn, input bit acc,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] alo, input logic [31:0] ahi);
      longint          sp;
      longint unsigned p;
      bit              use_s;
`ifdef MUL_SIGNED_EN
      use_s = lng && sgn;
`else
      use_s = 1'b0;
`endif
      if (use_s) begin
         sp = longint'($signed(a)) * longint'($signed(b));
         p  = longint'(sp);
      end else begin
         p = longint'({32'd0, a}) * longint'({32'd0, b});
      end
      if (acc) p = p + (lng ? {ahi, alo} : {32'd0, alo});
      if (!lng) p = {32'd0, p[31:0]};
      return p;
   endfunction

   always @(negedge clk) begin : cmp
      exp_t e;
      e = '0;
      if (!reset_n) begin
         exp_fn = 1'b0;
         exp_fz = 1'b0;
      end else if (exp_m.exists(cyc)) begin
         e = exp_m[cyc];
      end
      if (e.upd) begin
         exp_fn = e.fn;
         exp_fz = e.fz;
      end
      chk("busy",     {63'd0, bus.busy},     {63'd0, e.busy});
      chk("done",     {63'd0, bus.done},     {63'd0, e.done});
      chk("wr_en",    {63'd0, bus.wr_en},    {63'd0, e.wr_en});
      chk("flags_we", {63'd0, bus.flags_we}, {63'd0, e.fwe});
      chk("flag_n",   {63'd0, bus.flag_n},   {63'd0, exp_fn});
      chk("flag_z",   {63'd0, bus.flag_z},   {63'd0, exp_fz});
      if (e.wr_en || !reset_n) begin
         chk("wr_sel",  {63'd0, bus.wr_sel}, {63'd0, e.wr_sel});
         chk("wr_data", {32'd0, bus.wr_data}, {32'd0, e.data});
      end
   end

   task automatic rand_inputs();
      bus.long_en   = 1'($urandom);
      bus.signed_en = 1'($urandom);
      bus.acc_en    = 1'($urandom);
      bus.set_flags = 1'($urandom);
      bus.a         = $urandom;
      bus.b         = $urandom;
      bus.acc_lo    = $urandom;
      bus.acc_hi    = $urandom;
   endtask

   // Entered and left at posedge+1 of an IDLE cycle.
   task automatic run_op(input bit lng, input bit sgn, input bit acc, input bit sf,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alo, input logic [31:0] ahi,
                         input bit inj, output logic [63:0] res);
      int   c0, first, last;
      exp_t e;
      logic [1:0] f;
      bus.long_en = lng; bus.signed_en = sgn; bus.acc_en = acc; bus.set_flags = sf;
      bus.a = a; bus.b = b; bus.acc_lo = alo; bus.acc_hi = ahi;
      bus.start = 1'b1;
      c0    = cyc;
      res   = model_res(lng, sgn, acc, a, b, alo, ahi);
      f     = lng ? {res[63], res == 64'd0} : {res[31], res[31:0] == 32'd0};
      first = acc ? 3 : 2;
      last  = lng ? first + 1 : first;
      for (int k = 1; k <= last; k++) begin
         e      = '0;
         e.busy = 1'b1;
         if (k == first)     begin e.wr_en = 1'b1; e.wr_sel = 1'b0; e.data = res[31:0];  end
         if (k == first + 1) begin e.wr_en = 1'b1; e.wr_sel = 1'b1; e.data = res[63:32]; end
         if (k == last)      begin e.done = 1'b1; e.fwe = sf; e.upd = 1'b1; e.fn = f[1]; e.fz = f[0]; end
         exp_m[c0 + k] = e;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      rand_inputs();
      if (inj) begin
         bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         rand_inputs();
      end
      while (cyc <= c0 + last) begin
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] edges [6];
      edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFE};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin : wdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin : drv
      logic [63:0] r;
      int          c0;
      bus.start = 1'b0;
      rand_inputs();
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      // MUL 7*6
      run_op(0, 0, 0, 0, 32'd7, 32'd6, 32'd0, 32'd0, 0, r);
      chk("pin_mul", r, 64'h0000_0000_0000_002A);
      // MLA 0xFFFFFFFF*2 + 3, back-to-back
      run_op(0, 0, 1, 1, 32'hFFFFFFFF, 32'd2, 32'd3, 32'd0, 0, r);
      chk("pin_mla", r, 64'h0000_0000_0000_0001);
      // UMULL 0xFFFFFFFF^2
      run_op(1, 0, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 0, r);
      chk("pin_umull", r, 64'hFFFF_FFFE_0000_0001);
      // SMULL -2*3
      run_op(1, 1, 0, 1, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd0, 0, r);
`ifdef MUL_SIGNED_EN
      chk("pin_smull", r, 64'hFFFF_FFFF_FFFF_FFFA);
`else
      chk("pin_smull", r, 64'h0000_0002_FFFF_FFFA);
`endif
      // SMLAL (-2^31)^2 + 0xC0000000_00000000 wraps to zero
      run_op(1, 1, 1, 1, 32'h80000000, 32'h80000000, 32'h0, 32'hC0000000, 0, r);
      chk("pin_smlal", r, 64'h0);
      // start while busy is ignored
      run_op(1, 0, 1, 1, 32'h12345678, 32'h9ABCDEF0, 32'h1, 32'h2, 1, r);
      @(posedge clk); #1;

      // UMLAL aborted by reset in cycle 2
      bus.long_en = 1; bus.signed_en = 0; bus.acc_en = 1; bus.set_flags = 1;
      bus.a = 32'hDEADBEEF; bus.b = 32'h1234; bus.acc_lo = 32'h5; bus.acc_hi = 32'h6;
      bus.start = 1'b1;
      c0 = cyc;
      exp_m[c0 + 1] = '{busy: 1'b1, default: '0};
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      reset_n = 1'b0;
      #1;
      chk("rst_busy",  {63'd0, bus.busy},   64'd0);
      chk("rst_wr_en", {63'd0, bus.wr_en},  64'd0);
      chk("rst_done",  {63'd0, bus.done},   64'd0);
      chk("rst_data",  {32'd0, bus.wr_data}, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      for (int i = 0; i < 60; i++) begin
         int ty;
         ty = $urandom_range(0, 5);
         run_op((ty >= 2), (ty >= 4) ? 1'b1 : 1'($urandom), (ty % 2 == 1), 1'($urandom),
                pick(), pick(), pick(), pick(), ($urandom_range(0, 3) == 0), r);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multicycle sequencer for ARM multiply instructions (MUL, MLA, UMULL, UMLAL, SMULL, SMLAL). It sits beside the main datapath and wraps a combinational 32x32->64 unsigned multiplier, adding sign correction, accumulate, and flag generation. Results are written back over a single register-file write port, one 32-bit word per cycle. The control FSM starts it with a one-cycle `start` and stalls on `busy` until `done`.

## Interface
Parameters:
- `XLEN`, 32: operand and register width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request; accepted only in IDLE
- `long_en`  in  1  1 = 64-bit result (xMULL/xMLAL); 0 = 32-bit MUL/MLA
- `signed_en`  in  1  signed operands; only meaningful when `long_en`=1
- `acc_en`  in  1  accumulate (MLA/xMLAL)
- `set_flags`  in  1  S bit
- `a`, `b`  in  32 each  Rm and Rs values
- `acc_lo`, `acc_hi`  in  32 each  accumulator (Rn or RdLo, RdHi)
- `busy`  out  1  operation in flight
- `done`  out  1  one-cycle pulse in the final write cycle
- `wr_en`  out  1  register write strobe
- `wr_sel`  out  1  0 = Rd/RdLo, 1 = RdHi
- `wr_data`  out  32  write data
- `flags_we`  out  1  update N/Z; equals `done & set_flags`
- `flag_n`, `flag_z`  out  1 each  result flags

## Operation
- **Capture.** On `start` in IDLE, all inputs are registered. Later input changes have no effect. `start` while busy is ignored, with no queuing.
- **States:** IDLE -> MUL -> [ACC if `acc_en`] -> WLO -> [WHI if `long_en`] -> IDLE.
- **MUL.** The product register loads the `umul32` result of the operand magnitudes.
  - Signed: magnitude is `|x|`. 0x80000000 maps to 2^31, which is valid unsigned.
  - The 64-bit product is two's-complement negated when `a[31]^b[31]`.
  - Unsigned or short: raw operands are used, with no negation.
- **ACC.**
  - Short: `lo = prod[31:0] + acc_lo` mod 2^32.
  - Long: `prod + {acc_hi,acc_lo}` mod 2^64. Carries are discarded.
- **WLO.** `wr_en`=1, `wr_sel`=0, `wr_data`=result[31:0].
- **WHI.** `wr_en`=1, `wr_sel`=1, `wr_data`=result[63:32].
- **Flags.**
  - Short: N=result[31], Z=(result[31:0]==0).
  - Long: N=result[63], Z=(result[63:0]==0).
  - C and V are not produced.

## Timing
- Cycle 0 is the cycle where `start` is sampled high in IDLE.
- Write cycles:
  - MUL: WLO at cycle 2.
  - MLA: WLO at cycle 3.
  - UMULL/SMULL: WLO at 2, WHI at 3.
  - UMLAL/SMLAL: WLO at 3, WHI at 4.
- `busy`=1 from cycle 1 through the final write cycle inclusive. It drops in the cycle after `done`.
- `done`, `flags_we` and `flag_n/z` are valid only in the final write cycle. `flag_n/z` hold the last value otherwise.
- A back-to-back `start` is accepted in the first IDLE cycle after `done`.
- `wr_en`, `wr_sel` and `wr_data` are decoded from state and the result register only. There is no combinational path from inputs.
- **Reset.** Asynchronous assertion forces IDLE immediately. All outputs go to 0 (`busy`, `done`, `wr_en`, `wr_sel`, `wr_data`, `flags_we`, `flag_n`, `flag_z`). An in-flight operation is dropped with no further writes. Deassertion is synchronised externally.

## Configuration
- `MUL_SIGNED_EN` defined:
  - Magnitude/negate logic is present.
  - SMULL/SMLAL produce signed results.
- `MUL_SIGNED_EN` undefined:
  - `signed_en` is ignored.
  - All long operations are unsigned.
  - The negation logic is removed.
  - Latency is unchanged.

## Structure
- `mul_seq_pkg` holds:
  - the state enum (`S_IDLE`, `S_MUL`, `S_ACC`, `S_WLO`, `S_WHI`);
  - a packed `mul_op_t` struct (`long_en`, `signed_en`, `acc_en`, `set_flags`);
  - `WR_SEL_LO`/`WR_SEL_HI` constants.
- One sub-module, `umul32`: purely combinational unsigned 32x32->64. It is instantiated once. The sequencer owns all registers.

## Test plan
- MUL, a=7, b=6: cycle 2 shows `wr_en`=1, `wr_sel`=0, `wr_data`=0x0000002A, `done`=1. `busy` is high in cycles 1-2 only.
- MLA, a=0xFFFFFFFF, b=2, acc_lo=3, S=1: cycle 3 shows `wr_data`=0x00000001, N=0, Z=0, `flags_we`=1.
- UMULL, a=b=0xFFFFFFFF: cycle 2 writes lo 0x00000001, cycle 3 writes hi 0xFFFFFFFE. Inputs are changed after cycle 0 and the results must be unaffected.
- SMULL, a=0xFFFFFFFE, b=3, S=1:
  - With the macro: lo 0xFFFFFFFA, hi 0xFFFFFFFF, N=1.
  - Without the macro: lo 0xFFFFFFFA, hi 0x00000002, N=0.
- SMLAL, a=b=0x80000000, acc={0xC0000000,0x00000000}, S=1: lo 0, hi 0, Z=1, N=0, written in cycles 3 and 4.
- Reset and busy handling:
  - UMLAL started, with `reset_n` pulsed low in cycle 2: `busy`/`wr_en` drop to 0 immediately, and no writes occur afterwards.
  - A `start` during `busy` is ignored, with no extra writes.
